mc_ctrl: RTL and testbench

Multi-cycle main controller for the CPU: the driving end of the ALU operation interface. It sequences each instruction through fetch, decode, execute, memory and write-back states. In each cycle it issues `alu_op` in the ALU's 3-bit encoding together with the datapath select and write-enable strobes. It consumes the ALU `equal` flag to resolve branches and sits between the instruction register and the shared datapath (PC, register file, data memory, ALU).

---
 rtl/mc_ctrl_pkg.sv | 113 +++++++++++
 rtl/mc_ctrl_decode.sv | 51 +++++
 rtl/mc_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle main controller:
//   - FSM state enum (state_t)
//   - ALU operation codes in the ALU's 3-bit encoding
//   - MIPS opcode / funct constants of the decoded instruction subset
//   - datapath select encodings (alu_src_a/b, ext_op, reg_dst, mem_to_reg, pc_src)
//   - instruction class enum (iclass_t) produced by mc_ctrl_decode
// Configuration macro: MC_CTRL_JUMP_EN (adds the JMP state when defined).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // FSM states; JMP only exists when jump instructions are decoded
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BR     = 3'd5
`ifdef MC_CTRL_JUMP_EN
        ,
        ST_JMP    = 3'd6
`endif
    } state_t;

    // ALU operation encoding
    localparam logic [2:0] ALU_AND   = 3'd0;
    localparam logic [2:0] ALU_OR    = 3'd1;
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_SLTU  = 3'd3;
    localparam logic [2:0] ALU_PASSA = 3'd5;
    localparam logic [2:0] ALU_SUB   = 3'd6;
    localparam logic [2:0] ALU_EQ    = 3'd7;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU A-operand select
    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    // Immediate extension mode
    localparam logic [1:0] EXT_ZERO     = 2'd0;
    localparam logic [1:0] EXT_SIGN     = 2'd1;
    localparam logic [1:0] EXT_HI16     = 2'd2;
    localparam logic [1:0] EXT_SIGN_SH2 = 2'd3;

    // Register-file write address select
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Register-file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    // Instruction classes seen by the FSM
    typedef enum logic [3:0] {
        CL_ADDU    = 4'd0,
        CL_SUBU    = 4'd1,
        CL_AND     = 4'd2,
        CL_OR      = 4'd3,
        CL_SLTU    = 4'd4,
        CL_ORI     = 4'd5,
        CL_LUI     = 4'd6,
        CL_LW      = 4'd7,
        CL_SW      = 4'd8,
        CL_BEQ     = 4'd9,
        CL_J       = 4'd10,
        CL_JAL     = 4'd11,
        CL_JR      = 4'd12,
        CL_UNKNOWN = 4'd15
    } iclass_t;

    // True for register-register ALU instructions (write rd from ALUOut)
    function automatic logic is_r_alu(input iclass_t c);
        logic r_s;
        case (c)
            CL_ADDU, CL_SUBU, CL_AND, CL_OR, CL_SLTU: r_s = 1'b1;
            default:                                 r_s = 1'b0;
        endcase
        return r_s;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational instruction classifier: maps the primary opcode and the R-type
// funct field onto an instruction class. Anything outside the decoded subset
// becomes CL_UNKNOWN.
// Configuration macro: MC_CTRL_JUMP_EN -- when undefined, j/jal/jr are
// reported as CL_UNKNOWN.
// Ports:
//   opcode  in  6   instr[31:26]
//   funct   in  6   instr[5:0]
//   iclass  out     instruction class (iclass_t)
// -----------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    // Opcode / funct to class lookup
    always_comb begin
        iclass = CL_UNKNOWN;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = CL_ADDU;
                    FN_SUBU: iclass = CL_SUBU;
                    FN_AND:  iclass = CL_AND;
                    FN_OR:   iclass = CL_OR;
                    FN_SLTU: iclass = CL_SLTU;
`ifdef MC_CTRL_JUMP_EN
                    FN_JR:   iclass = CL_JR;
`endif
                    default: iclass = CL_UNKNOWN;
                endcase
            end
            OP_ORI:  iclass = CL_ORI;
            OP_LUI:  iclass = CL_LUI;
            OP_LW:   iclass = CL_LW;
            OP_SW:   iclass = CL_SW;
            OP_BEQ:  iclass = CL_BEQ;
`ifdef MC_CTRL_JUMP_EN
            OP_J:    iclass = CL_J;
            OP_JAL:  iclass = CL_JAL;
`endif
            default: iclass = CL_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle main controller. Walks each instruction through FETCH, DECODE,
// EXEC, MEM, WB, BR (and JMP when enabled) and drives the ALU operation,
// datapath selects and write strobes for the shared datapath. Outputs are
// combinational from the registered state, the instruction class and `equal`.
// Configuration macro: MC_CTRL_JUMP_EN -- enables j/jal/jr and the JMP state.
// Parameters:
//   CNT_W       width of the retired-instruction counter
// Ports:
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   instr       in   32     instruction register contents
//   equal       in   1      ALU compare flag (used only in BR)
//   alu_op      out  3      ALU operation
//   alu_src_a   out  1      0 PC, 1 rs
//   alu_src_b   out  2      0 rt, 1 four, 2 extended immediate
//   ext_op      out  2      immediate extension mode
//   reg_dst     out  2      0 rt, 1 rd, 2 $31
//   mem_to_reg  out  2      0 ALUOut, 1 MDR, 2 PC
//   pc_src      out  2      0 ALU, 1 ALUOut, 2 jump target, 3 rs
//   pc_write, ir_write, reg_write, mem_write   out 1   write strobes
//   instr_done  out  1      pulse in the last state of a legal instruction
//   instr_cnt   out  CNT_W  retired legal instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             equal,
    output logic [2:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t            state_r;
    state_t            next_state_s;
    iclass_t           iclass_s;
    logic              pc_write_s;
    logic              ir_write_s;
    logic              reg_write_s;
    logic              mem_write_s;
    logic              instr_done_s;
    logic [CNT_W-1:0]  instr_cnt_r;
    // Register and immediate fields are consumed by the datapath, not here
    logic              unused_instr_bits_s;

    assign unused_instr_bits_s = ^instr[25:6];

    mc_ctrl_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .iclass (iclass_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: next_state_s = ST_DECODE;
            ST_DECODE: begin
                case (iclass_s)
                    CL_ADDU, CL_SUBU, CL_AND, CL_OR, CL_SLTU,
                    CL_ORI, CL_LUI, CL_LW, CL_SW: next_state_s = ST_EXEC;
                    CL_BEQ:                       next_state_s = ST_BR;
`ifdef MC_CTRL_JUMP_EN
                    CL_J, CL_JAL, CL_JR:          next_state_s = ST_JMP;
`endif
                    default:                      next_state_s = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                if ((iclass_s == CL_LW) || (iclass_s == CL_SW)) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (iclass_s == CL_LW) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB:  next_state_s = ST_FETCH;
            ST_BR:  next_state_s = ST_FETCH;
`ifdef MC_CTRL_JUMP_EN
            ST_JMP: next_state_s = ST_FETCH;
`endif
            default: next_state_s = ST_FETCH;
        endcase
    end

    // Output decode: selects go straight to the ports, strobes are raw here
    always_comb begin
        alu_op       = ALU_ADD;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RT;
        ext_op       = EXT_ZERO;
        reg_dst      = DST_RT;
        mem_to_reg   = M2R_ALUOUT;
        pc_src       = PC_ALU;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        instr_done_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // Latch IR and advance PC by 4 in the same cycle
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                pc_src     = PC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target PC + (sext(imm) << 2) into ALUOut
                alu_src_b = SRCB_IMM;
                ext_op    = EXT_SIGN_SH2;
            end
            ST_EXEC: begin
                alu_src_a = SRCA_RS;
                case (iclass_s)
                    CL_ADDU: alu_op = ALU_ADD;
                    CL_SUBU: alu_op = ALU_SUB;
                    CL_AND:  alu_op = ALU_AND;
                    CL_OR:   alu_op = ALU_OR;
                    CL_SLTU: alu_op = ALU_SLTU;
                    CL_ORI: begin
                        alu_src_b = SRCB_IMM;
                        ext_op    = EXT_ZERO;
                        alu_op    = ALU_OR;
                    end
                    CL_LUI: begin
                        // rs is $0, so ADD yields imm << 16
                        alu_src_b = SRCB_IMM;
                        ext_op    = EXT_HI16;
                        alu_op    = ALU_ADD;
                    end
                    CL_LW, CL_SW: begin
                        alu_src_b = SRCB_IMM;
                        ext_op    = EXT_SIGN;
                        alu_op    = ALU_ADD;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                if (iclass_s == CL_SW) begin
                    mem_write_s  = 1'b1;
                    instr_done_s = 1'b1;
                end else begin
                    mem_write_s  = 1'b0;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                if (is_r_alu(iclass_s)) begin
                    reg_dst = DST_RD;
                end else begin
                    reg_dst = DST_RT;
                end
                if (iclass_s == CL_LW) begin
                    mem_to_reg = M2R_MDR;
                end else begin
                    mem_to_reg = M2R_ALUOUT;
                end
            end
            ST_BR: begin
                // Compare rs/rt; take the target computed in DECODE on equal
                alu_src_a    = SRCA_RS;
                alu_src_b    = SRCB_RT;
                alu_op       = ALU_EQ;
                pc_src       = PC_ALUOUT;
                pc_write_s   = equal;
                instr_done_s = 1'b1;
            end
`ifdef MC_CTRL_JUMP_EN
            ST_JMP: begin
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
                case (iclass_s)
                    CL_J: pc_src = PC_JUMP;
                    CL_JAL: begin
                        // PC already holds PC+4 from FETCH: that is the link value
                        pc_src      = PC_JUMP;
                        reg_write_s = 1'b1;
                        reg_dst     = DST_RA;
                        mem_to_reg  = M2R_PC;
                    end
                    CL_JR:   pc_src = PC_RS;
                    default: pc_src = PC_ALU;
                endcase
            end
`endif
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
    end

    // Strobes are masked for the whole time reset is high
    assign pc_write   = pc_write_s   & ~reset;
    assign ir_write   = ir_write_s   & ~reset;
    assign reg_write  = reg_write_s  & ~reset;
    assign mem_write  = mem_write_s  & ~reset;
    assign instr_done = instr_done_s & ~reset;

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_r <= '0;
        end else if (instr_done) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Self-checking bench for mc_ctrl. A directed table of instructions is run
// first, then a reset-during-store sequence, then randomized instructions with
// random `equal` every cycle. Expected outputs come from an instruction-level
// model that lists, for each instruction kind, what each cycle must drive.
// A small counter width is used so wrap-around is exercised.
// Honours MC_CTRL_JUMP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    localparam int CNT_W = 4;
`ifdef MC_CTRL_JUMP_EN
    localparam bit JUMP = 1'b1;
`else
    localparam bit JUMP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      instr = 32'h0;
    logic             equal = 1'b0;
    logic [2:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       ext_op;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       pc_src;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_write;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .equal      (equal),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .instr_done (instr_done),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] ext;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic [1:0] pcsrc;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       done;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        int          cycles;
        out_t        last;
    } vec_t;

    out_t act_s;
    assign act_s = {alu_op, alu_src_a, alu_src_b, ext_op, reg_dst, mem_to_reg,
                    pc_src, pc_write, ir_write, reg_write, mem_write, instr_done};

    int               vectors = 0;
    int               errors  = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    function automatic out_t mk(int op, int sa, int sb, int ex, int rd, int mr, int ps,
                                int pw, int iw, int rw, int mw, int dn);
        out_t o;
        o.alu_op = 3'(op);  o.src_a = 1'(sa); o.src_b = 2'(sb); o.ext = 2'(ex);
        o.rdst   = 2'(rd);  o.m2r   = 2'(mr); o.pcsrc = 2'(ps);
        o.pcw    = 1'(pw);  o.irw   = 1'(iw); o.rw    = 1'(rw);
        o.mw     = 1'(mw);  o.done  = 1'(dn);
        return o;
    endfunction

    // Instruction kind by name; jumps are illegal when the feature is off
    function automatic string kind_of(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h21) return "addu";
            if (fn == 6'h23) return "subu";
            if (fn == 6'h24) return "and";
            if (fn == 6'h25) return "or";
            if (fn == 6'h2B) return "sltu";
            if (fn == 6'h08 && JUMP) return "jr";
            return "bad";
        end
        if (op == 6'h0D) return "ori";
        if (op == 6'h0F) return "lui";
        if (op == 6'h23) return "lw";
        if (op == 6'h2B) return "sw";
        if (op == 6'h04) return "beq";
        if (op == 6'h02 && JUMP) return "j";
        if (op == 6'h03 && JUMP) return "jal";
        return "bad";
    endfunction

    function automatic int n_steps(input logic [31:0] i);
        string k;
        k = kind_of(i);
        if (k == "bad") return 2;
        if (k == "beq" || k == "j" || k == "jal" || k == "jr") return 3;
        if (k == "lw") return 5;
        return 4;
    endfunction

    // Expected outputs in cycle k (0 = fetch) of instruction i
    function automatic out_t exp_out(input logic [31:0] i, input int k, input logic eq);
        string kd;
        int    op;
        kd = kind_of(i);
        if (k == 0) return mk(2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        if (k == 1) return mk(2, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        if (kd == "beq") return mk(7, 1, 0, 0, 0, 0, 1, int'(eq), 0, 0, 0, 1);
        if (kd == "j")   return mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1);
        if (kd == "jal") return mk(2, 0, 0, 0, 2, 2, 2, 1, 0, 1, 0, 1);
        if (kd == "jr")  return mk(2, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        if (k == 2) begin
            if (kd == "ori") return mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (kd == "lui") return mk(2, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
            if (kd == "lw" || kd == "sw") return mk(2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            op = (kd == "addu") ? 2 : (kd == "subu") ? 6 : (kd == "and") ? 0 :
                 (kd == "or") ? 1 : 3;
            return mk(op, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        if (k == 3) begin
            if (kd == "sw") return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            if (kd == "lw") return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (kd == "ori" || kd == "lui") return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            return mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        end
        return mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %05h expected %05h", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp);
        vectors++;
        if (instr_cnt !== exp) begin
            errors++;
            $display("FAIL %s: instr_cnt got %0d expected %0d", name, instr_cnt, exp);
        end
    endtask

    // One clock of instruction i; entered at posedge+1, leaves at next posedge+1
    task automatic step(input logic [31:0] i, input int k, input logic eq, output out_t got);
        string nm;
        instr = i;
        equal = eq;
        nm = $sformatf("%s@%08h cyc%0d", kind_of(i), i, k);
        @(negedge clk);
        got = act_s;
        check_out(nm, act_s, exp_out(i, k, eq));
        check_cnt(nm, model_cnt);
        if (k == n_steps(i) - 1 && kind_of(i) != "bad") model_cnt = model_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rand(input logic [31:0] i);
        out_t g;
        for (int k = 0; k < n_steps(i); k++) begin
            step(i, k, 1'($urandom_range(0, 1)), g);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [5];
        logic [5:0] ops [7];
        int r;
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        ops = '{6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03};
        r = $urandom_range(0, 13);
        if (r < 5) return {6'h00, 20'($urandom), fns[r]};
        if (r == 5) return {6'h00, 20'($urandom), 6'h08};
        if (r < 13) return {ops[r - 6], 26'($urandom)};
        return $urandom;
    endfunction

    localparam out_t RST_VEC = '{alu_op: 3'd2, src_a: 1'b0, src_b: 2'd1, ext: 2'd0,
                                 rdst: 2'd0, m2r: 2'd0, pcsrc: 2'd0, pcw: 1'b0,
                                 irw: 1'b0, rw: 1'b0, mw: 1'b0, done: 1'b0};

    vec_t tbl[11];

    initial begin
        out_t g;
        int   k;

        tbl[0]  = '{32'h34080005, 1'b0, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1)}; // ori
        tbl[1]  = '{32'h8D090004, 1'b0, 5, mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1)}; // lw
        tbl[2]  = '{32'h11090002, 1'b1, 3, mk(7, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1)}; // beq taken
        tbl[3]  = '{32'h11090002, 1'b0, 3, mk(7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1)}; // beq not taken
        tbl[4]  = '{32'hAD090000, 1'b0, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)}; // sw
        tbl[5]  = '{32'hFC000000, 1'b1, 2, mk(2, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0)}; // unknown
        tbl[6]  = '{32'h014B4821, 1'b0, 4, mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1)}; // addu
        tbl[7]  = '{32'h3C081234, 1'b0, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1)}; // lui
`ifdef MC_CTRL_JUMP_EN
        tbl[8]  = '{32'h0C000C00, 1'b0, 3, mk(2, 0, 0, 0, 2, 2, 2, 1, 0, 1, 0, 1)}; // jal
        tbl[9]  = '{32'h08000010, 1'b0, 3, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1)}; // j
        tbl[10] = '{32'h03E00008, 1'b0, 3, mk(2, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1)}; // jr
`else
        tbl[8]  = '{32'h0C000C00, 1'b0, 2, mk(2, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0)}; // jal as unknown
        tbl[9]  = '{32'h08000010, 1'b0, 2, mk(2, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0)}; // j as unknown
        tbl[10] = '{32'h03E00008, 1'b0, 2, mk(2, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0)}; // jr as unknown
`endif

        // Reset state: FETCH selects, no strobes, zero count
        repeat (2) @(posedge clk);
        #1;
        check_out("reset outputs", act_s, RST_VEC);
        check_cnt("reset count", '0);
        reset = 1'b0;

        // Directed table; `equal` held at the record value for the whole instruction
        for (int t = 0; t < 11; t++) begin
            for (k = 0; k < tbl[t].cycles; k++) begin
                step(tbl[t].instr, k, tbl[t].eq, g);
            end
            check_out($sformatf("table[%0d] last cycle", t), g, tbl[t].last);
        end

        // Reset while a store sits in MEM: strobe must drop immediately
        for (k = 0; k < 3; k++) begin
            step(32'hAD090000, k, 1'b0, g);
        end
        instr = 32'hAD090000;
        @(negedge clk);
        check_out("sw MEM before reset", act_s, exp_out(32'hAD090000, 3, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check_out("sw reset mid-MEM", act_s, RST_VEC);
        check_cnt("sw reset mid-MEM count", '0);
        model_cnt = '0;
        @(posedge clk);
        #1;
        check_out("held in reset", act_s, RST_VEC);
        reset = 1'b0;
        // First cycle after release must be a full FETCH
        run_rand(32'h34080005);

        // Randomized instructions with random `equal` every cycle
        for (int n = 0; n < 300; n++) begin
            run_rand(rand_instr());
        end

        @(negedge clk);
        check_cnt("final count", model_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

endmodule
